settings_edit_ctrl: RTL and testbench
=====================================

// Module: settings_edit_ctrl
// PURPOSE
//   Sequences the advanced-settings editor of the hood controller: selects one of three
//   timing slots (1 clean, 2 gesture, 3 system-time), edits hour/min/sec in shadow registers,
//   and commits them on confirm.
//   Sits between the debounced button layer and the seg-display driver and mode timers.
//   Owns the committed slot values.
// PARAMETERS
//   TIMEOUT_CYC  1_000_000_000  inactivity cycles in SEL/EDIT before forced exit (10 s @100 MHz)
//   DEF1_TIME    17'h00_0C0     slot1 default {hour[16:12],min[11:6],sec[5:0]} = 0:03:00
//   DEF2_TIME    17'h00_005     slot2 default 0:00:05
//   DEF3_TIME    17'h0A_000     slot3 default 10:00:00
// PORTS
//   clk               in   1   system clock
//   rst               in   1   reset, synchronous, active-high
//   settings_en       in   1   level; advanced-settings switch
//   mode_btn          in   3   one-hot pulse; bit0 slot1, bit1 slot2, bit2 slot3
//   field_btn         in   1   pulse; advance edit field
//   inc_btn           in   1   pulse; increment current field
//   confirm_btn       in   1   pulse; commit shadow to slot
//   init_btn          in   1   pulse; restore all defaults
//   in_settings_mode  out  1   1 when state != IDLE
//   state_o           out  2   0 IDLE, 1 SEL, 2 EDIT, 3 COMMIT
//   edit_slot         out  2   0 none, 1..3 slot being edited
//   edit_field        out  2   0 hour, 1 min, 2 sec
//   edit_time         out  17  shadow value for display, packed as DEF*_TIME
//   commit_pulse      out  1   one-cycle strobe when slot written
//   slot1_time        out  17  committed slot1
//   slot2_time        out  17  committed slot2
//   slot3_time        out  17  committed slot3
// BEHAVIOUR
//   Reset: state IDLE; slotN_time = DEFN_TIME; edit_time, edit_slot, edit_field = 0;
//     commit_pulse = 0; inactivity counter = 0. All outputs registered.
//   Same-cycle priority: rst > settings_en==0 > init_btn > confirm_btn > mode_btn > field_btn > inc_btn.
//     Only the highest-priority event acts.
//   IDLE: all buttons ignored. settings_en==1 -> SEL next edge.
//     in_settings_mode rises 1 cycle after settings_en.
//   SEL: mode_btn with exactly one bit set -> edit_time <= that slot's value, edit_slot set,
//     edit_field = 0, -> EDIT. Zero or multiple bits set: ignored.
//   EDIT:
//     - field_btn: field 0->1->2->0.
//     - inc_btn: hour 23->0, min/sec 59->0, other fields untouched.
//     - valid mode_btn: discard shadow, load the new slot, field = 0, stay EDIT.
//     - confirm_btn -> COMMIT.
//   COMMIT (1 cycle): slot[edit_slot] <= edit_time; commit_pulse = 1; -> SEL; edit_slot <= 0.
//   settings_en==0 in SEL/EDIT -> IDLE next edge; shadow discarded, slots unchanged.
//     In COMMIT the write completes, then -> IDLE.
//   init_btn (state != IDLE): all slots <= defaults; edit_time, edit_slot, edit_field <= 0; -> SEL.
//     No commit_pulse.
//   Inactivity: counter clears on any button pulse and in IDLE/COMMIT.
//     In SEL/EDIT, reaching TIMEOUT_CYC-1 -> IDLE, shadow discarded.
//   rst mid-edit: everything returns to the reset values above, including slots.
// STRUCTURE
//   Shared header settings_defs.vh:
//     - state codes, field codes, HOUR_MAX = 23, MS_MAX = 59;
//     - pack/unpack bit ranges;
//     - default-time constants.
//   Sub-module time_field_editor: shadow register plus wrap-increment and load logic.
//     Top holds the FSM, inactivity counter and slot registers.
// TESTING
//   1 rst, settings_en=1 -> in_settings_mode=1 after 1 edge; slots = 0:03:00 / 0:00:05 / 10:00:00.
//   2 mode_btn=001, 2x field_btn, 3x inc_btn, confirm -> commit_pulse 1 cycle;
//     slot1_time = 0:03:03; state back to SEL.
//   3 slot3 hour=23, inc_btn -> hour 0, min/sec unchanged; slot2 sec=59, inc_btn -> sec 0.
//   4 edit slot2, settings_en=0 before confirm -> IDLE; slot2 still 0:00:05; no commit_pulse.
//   5 confirm_btn and inc_btn same cycle -> commit only;
//     init_btn and confirm_btn same cycle -> defaults, no commit_pulse.
//   6 TIMEOUT_CYC=16, enter EDIT, no buttons -> IDLE after 16 cycles;
//     mode_btn=011 in SEL ignored.

Source files
------------

// File: rtl/settings_edit_ctrl_pkg.sv
// Shared types and constants for the advanced-settings editor.
package settings_edit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEL    = 2'd1,
    ST_EDIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FLD_HOUR = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_SEC  = 2'd2
  } field_t;

  localparam int unsigned TIME_W = 17;

  // Packed time layout {hour, min, sec}
  localparam int unsigned HOUR_HI = 16;
  localparam int unsigned HOUR_LO = 12;
  localparam int unsigned MIN_HI  = 11;
  localparam int unsigned MIN_LO  = 6;
  localparam int unsigned SEC_HI  = 5;
  localparam int unsigned SEC_LO  = 0;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  localparam logic [TIME_W-1:0] DEF1_TIME_C = 17'h000C0;  // 0:03:00
  localparam logic [TIME_W-1:0] DEF2_TIME_C = 17'h00005;  // 0:00:05
  localparam logic [TIME_W-1:0] DEF3_TIME_C = 17'h0A000;  // 10:00:00

  // Slot index 1..3 for a one-hot mode button vector, 0 when not exactly one bit set.
  function automatic logic [1:0] slot_of(input logic [2:0] m);
    case (m)
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      3'b100:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/settings_edit_ctrl_time_field_editor.sv
// Shadow time register with field select, wrap-around increment and slot load.
module time_field_editor
  import settings_edit_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              adv,
  input  logic              inc,
  output logic [TIME_W-1:0] edit_time,
  output logic [1:0]        edit_field
);

  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] inc_val;
  field_t            field_q;
  logic [4:0]        hour;
  logic [5:0]        min;
  logic [5:0]        sec;

  // Increment only the selected field, wrapping at its maximum.
  always_comb begin
    hour    = time_q[HOUR_HI:HOUR_LO];
    min     = time_q[MIN_HI:MIN_LO];
    sec     = time_q[SEC_HI:SEC_LO];
    inc_val = time_q;
    case (field_q)
      FLD_HOUR: inc_val[HOUR_HI:HOUR_LO] = (hour == HOUR_MAX) ? '0 : hour + 5'd1;
      FLD_MIN:  inc_val[MIN_HI:MIN_LO]   = (min == MS_MAX)    ? '0 : min + 6'd1;
      FLD_SEC:  inc_val[SEC_HI:SEC_LO]   = (sec == MS_MAX)    ? '0 : sec + 6'd1;
      default:  inc_val = time_q;
    endcase
  end

  // Shadow register and field pointer; commands arrive already prioritised.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      time_q  <= '0;
      field_q <= FLD_HOUR;
    end else if (load) begin
      time_q  <= load_val;
      field_q <= FLD_HOUR;
    end else if (adv) begin
      case (field_q)
        FLD_HOUR: field_q <= FLD_MIN;
        FLD_MIN:  field_q <= FLD_SEC;
        default:  field_q <= FLD_HOUR;
      endcase
    end else if (inc) begin
      time_q <= inc_val;
    end
  end

  assign edit_time  = time_q;
  assign edit_field = field_q;

endmodule

// File: rtl/settings_edit_ctrl.sv
// Advanced-settings editor sequencer: slot select, shadow edit, commit, timeout.
module settings_edit_ctrl
  import settings_edit_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = 1_000_000_000,
  parameter logic [TIME_W-1:0] DEF1_TIME   = DEF1_TIME_C,
  parameter logic [TIME_W-1:0] DEF2_TIME   = DEF2_TIME_C,
  parameter logic [TIME_W-1:0] DEF3_TIME   = DEF3_TIME_C
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              settings_en,
  input  logic [2:0]        mode_btn,
  input  logic              field_btn,
  input  logic              inc_btn,
  input  logic              confirm_btn,
  input  logic              init_btn,
  output logic              in_settings_mode,
  output logic [1:0]        state_o,
  output logic [1:0]        edit_slot,
  output logic [1:0]        edit_field,
  output logic [TIME_W-1:0] edit_time,
  output logic              commit_pulse,
  output logic [TIME_W-1:0] slot1_time,
  output logic [TIME_W-1:0] slot2_time,
  output logic [TIME_W-1:0] slot3_time
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t            state_q, state_n;
  logic [31:0]       idle_cnt;
  logic              any_btn;
  logic              timeout_hit;
  logic [1:0]        mode_slot;
  logic [TIME_W-1:0] load_val;
  logic              ed_clr, ed_load, ed_adv, ed_inc;
  logic              slot_wr, slots_init;

  // Next state and one-hot editor commands; only the highest-priority event acts.
  always_comb begin
    state_n     = state_q;
    ed_clr      = 1'b0;
    ed_load     = 1'b0;
    ed_adv      = 1'b0;
    ed_inc      = 1'b0;
    slot_wr     = 1'b0;
    slots_init  = 1'b0;
    mode_slot   = slot_of(mode_btn);
    any_btn     = (|mode_btn) | field_btn | inc_btn | confirm_btn | init_btn;
    timeout_hit = (idle_cnt == TO_LAST);
    case (state_q)
      ST_IDLE: begin
        if (settings_en) state_n = ST_SEL;
      end
      ST_SEL, ST_EDIT: begin
        if (!settings_en) begin
          state_n = ST_IDLE;
          ed_clr  = 1'b1;
        end else if (init_btn) begin
          state_n    = ST_SEL;
          slots_init = 1'b1;
          ed_clr     = 1'b1;
        end else if (confirm_btn) begin
          if (state_q == ST_EDIT) state_n = ST_COMMIT;
        end else if (mode_slot != 2'd0) begin
          state_n = ST_EDIT;
          ed_load = 1'b1;
        end else if (field_btn) begin
          ed_adv = (state_q == ST_EDIT);
        end else if (inc_btn) begin
          ed_inc = (state_q == ST_EDIT);
        end else if (!any_btn && timeout_hit) begin
          state_n = ST_IDLE;
          ed_clr  = 1'b1;
        end
      end
      ST_COMMIT: begin
        // A concurrent init wins over the write; a dropped enable still lets the write land.
        if (settings_en && init_btn) begin
          state_n    = ST_SEL;
          slots_init = 1'b1;
          ed_clr     = 1'b1;
        end else begin
          slot_wr = 1'b1;
          ed_clr  = 1'b1;
          state_n = settings_en ? ST_SEL : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Source value for a slot load.
  always_comb begin
    case (mode_slot)
      2'd1:    load_val = slot1_time;
      2'd2:    load_val = slot2_time;
      2'd3:    load_val = slot3_time;
      default: load_val = '0;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      in_settings_mode <= 1'b0;
      commit_pulse     <= 1'b0;
    end else begin
      state_q          <= state_n;
      in_settings_mode <= (state_n != ST_IDLE);
      commit_pulse     <= slot_wr;
    end
  end

  // Slot currently being edited.
  always_ff @(posedge clk) begin
    if (rst || ed_clr) begin
      edit_slot <= '0;
    end else if (ed_load) begin
      edit_slot <= mode_slot;
    end
  end

  // Committed slot values.
  always_ff @(posedge clk) begin
    if (rst || slots_init) begin
      slot1_time <= DEF1_TIME;
      slot2_time <= DEF2_TIME;
      slot3_time <= DEF3_TIME;
    end else if (slot_wr) begin
      case (edit_slot)
        2'd1:    slot1_time <= edit_time;
        2'd2:    slot2_time <= edit_time;
        2'd3:    slot3_time <= edit_time;
        default: ;
      endcase
    end
  end

  // Inactivity counter, running only while waiting in SEL/EDIT.
  always_ff @(posedge clk) begin
    if (rst || any_btn || timeout_hit ||
        state_q == ST_IDLE || state_q == ST_COMMIT) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  time_field_editor u_editor (
    .clk        (clk),
    .rst        (rst),
    .clr        (ed_clr),
    .load       (ed_load),
    .load_val   (load_val),
    .adv        (ed_adv),
    .inc        (ed_inc),
    .edit_time  (edit_time),
    .edit_field (edit_field)
  );

  assign state_o = state_q;

endmodule

// File: tb/tb_settings_edit_ctrl.sv
// Directed bench for settings_edit_ctrl with a short inactivity timeout.
module tb_settings_edit_ctrl;

  logic        clk = 1'b0;
  logic        rst, settings_en, field_btn, inc_btn, confirm_btn, init_btn;
  logic [2:0]  mode_btn;
  logic        in_settings_mode, commit_pulse;
  logic [1:0]  state_o, edit_slot, edit_field;
  logic [16:0] edit_time, slot1_time, slot2_time, slot3_time;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  settings_edit_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .settings_en      (settings_en),
    .mode_btn         (mode_btn),
    .field_btn        (field_btn),
    .inc_btn          (inc_btn),
    .confirm_btn      (confirm_btn),
    .init_btn         (init_btn),
    .in_settings_mode (in_settings_mode),
    .state_o          (state_o),
    .edit_slot        (edit_slot),
    .edit_field       (edit_field),
    .edit_time        (edit_time),
    .commit_pulse     (commit_pulse),
    .slot1_time       (slot1_time),
    .slot2_time       (slot2_time),
    .slot3_time       (slot3_time)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic press_mode(input logic [2:0] m);
    mode_btn = m;
    tick();
    mode_btn = 3'b000;
  endtask

  task automatic press_field();
    field_btn = 1'b1;
    tick();
    field_btn = 1'b0;
  endtask

  task automatic press_inc();
    inc_btn = 1'b1;
    tick();
    inc_btn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; settings_en = 1'b0; mode_btn = 3'b000;
    field_btn = 1'b0; inc_btn = 1'b0; confirm_btn = 1'b0; init_btn = 1'b0;
    tick(); tick();
    check("rst_state", state_o, 0);
    check("rst_mode", in_settings_mode, 0);
    check("rst_etime", edit_time, 0);
    check("rst_pulse", commit_pulse, 0);
    check("rst_s1", slot1_time, 17'h000C0);
    check("rst_s2", slot2_time, 17'h00005);
    check("rst_s3", slot3_time, 17'h0A000);
    rst = 1'b0;

    // Enter settings
    settings_en = 1'b1;
    tick();
    check("en_mode", in_settings_mode, 1);
    check("en_state", state_o, 1);

    // Edit slot1 seconds +3 and commit
    press_mode(3'b001);
    check("s1_state", state_o, 2);
    check("s1_slot", edit_slot, 1);
    check("s1_load", edit_time, 17'h000C0);
    check("s1_field0", edit_field, 0);
    press_field(); press_field();
    check("s1_field2", edit_field, 2);
    press_inc(); press_inc(); press_inc();
    check("s1_sec3", edit_time, 17'h000C3);
    confirm_btn = 1'b1; tick(); confirm_btn = 1'b0;
    check("s1_commit_st", state_o, 3);
    check("s1_nopulse", commit_pulse, 0);
    tick();
    check("s1_pulse", commit_pulse, 1);
    check("s1_value", slot1_time, 17'h000C3);
    check("s1_back_sel", state_o, 1);
    check("s1_slot_clr", edit_slot, 0);
    tick();
    check("s1_pulse_end", commit_pulse, 0);

    // Slot3: set min=2, then hour 10 -> 23 -> 0
    press_mode(3'b100);
    check("s3_load", edit_time, 17'h0A000);
    press_field();
    press_inc(); press_inc();
    check("s3_min2", edit_time, 17'h0A080);
    press_field(); press_field();
    check("s3_field_wrap", edit_field, 0);
    for (int i = 0; i < 13; i++) press_inc();
    check("s3_hour23", edit_time, 17'h17080);
    press_inc();
    check("s3_hour_wrap", edit_time, 17'h00080);

    // Slot2 sec 5 -> 59 -> 0, replacing slot3 shadow
    press_mode(3'b010);
    check("s2_slot", edit_slot, 2);
    check("s2_load", edit_time, 17'h00005);
    press_field(); press_field();
    for (int i = 0; i < 54; i++) press_inc();
    check("s2_sec59", edit_time, 17'h0003B);
    press_inc();
    check("s2_sec_wrap", edit_time, 17'h00000);

    // Drop enable mid-edit
    settings_en = 1'b0;
    tick();
    check("off_state", state_o, 0);
    check("off_mode", in_settings_mode, 0);
    check("off_slot", edit_slot, 0);
    check("off_s2", slot2_time, 17'h00005);
    check("off_pulse", commit_pulse, 0);
    settings_en = 1'b1;
    tick();
    check("reenter", state_o, 1);

    // confirm + inc same cycle
    press_mode(3'b010);
    press_inc();
    check("p_hour1", edit_time, 17'h01005);
    confirm_btn = 1'b1; inc_btn = 1'b1; tick();
    confirm_btn = 1'b0; inc_btn = 1'b0;
    check("p_commit_st", state_o, 3);
    check("p_no_inc", edit_time, 17'h01005);
    tick();
    check("p_pulse", commit_pulse, 1);
    check("p_s2", slot2_time, 17'h01005);

    // init + confirm same cycle
    press_mode(3'b001);
    check("i_load", edit_time, 17'h000C3);
    init_btn = 1'b1; confirm_btn = 1'b1; tick();
    init_btn = 1'b0; confirm_btn = 1'b0;
    check("i_state", state_o, 1);
    check("i_nopulse", commit_pulse, 0);
    check("i_s1", slot1_time, 17'h000C0);
    check("i_s2", slot2_time, 17'h00005);
    check("i_s3", slot3_time, 17'h0A000);
    check("i_etime", edit_time, 0);
    check("i_slot", edit_slot, 0);
    tick();
    check("i_nopulse2", commit_pulse, 0);

    // Invalid mode ignored, then timeout in EDIT
    press_mode(3'b011);
    check("m011_state", state_o, 1);
    check("m011_slot", edit_slot, 0);
    press_mode(3'b100);
    check("to_edit", state_o, 2);
    for (int i = 0; i < 15; i++) tick();
    check("to_before", state_o, 2);
    tick();
    check("to_idle", state_o, 0);
    check("to_etime", edit_time, 0);

    // Reset mid-edit restores committed slots
    tick();
    check("to_resel", state_o, 1);
    press_mode(3'b001);
    press_inc();
    confirm_btn = 1'b1; tick(); confirm_btn = 1'b0;
    tick();
    check("r_s1_commit", slot1_time, 17'h010C0);
    press_mode(3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_state", state_o, 0);
    check("r_s1", slot1_time, 17'h000C0);
    check("r_slot", edit_slot, 0);
    check("r_mode", in_settings_mode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
